// File: rtl/store_buffer.sv
// Speculative store buffer: holds executed stores in program order until commit, drains them to the cache,
// and answers store-to-load forwarding lookups. Define STORE_BUFFER_SUBWORD_FWD_EN for sub-word forwarding.
module store_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 32,
  parameter int MICROOP    = 5,
  parameter int ROB_TICKET = 3,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  st_valid,
  input  logic [ADDR_BITS-1:0]  st_address,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic [MICROOP-1:0]    st_microop,
  input  logic [ROB_TICKET-1:0] st_ticket,
  output logic                  full,
  output logic                  empty,
  input  logic                  commit_valid,
  input  logic [ROB_TICKET-1:0] commit_ticket,
  input  logic                  flush,
  input  logic [ADDR_BITS-1:0]  frw_address,
  input  logic [MICROOP-1:0]    frw_microop,
  output logic [DATA_WIDTH-1:0] frw_data,
  output logic                  frw_valid,
  output logic                  frw_stall,
  output logic                  cache_wb_valid,
  output logic [ADDR_BITS-1:0]  cache_wb_addr,
  output logic [DATA_WIDTH-1:0] cache_wb_data,
  output logic [MICROOP-1:0]    cache_wb_microop,
  input  logic                  cache_wb_ready
);

  localparam int PW  = $clog2(DEPTH);
  localparam int PW1 = PW + 1;

  localparam logic [MICROOP-1:0] OP_LW = MICROOP'(3);
  localparam logic [MICROOP-1:0] OP_SW = MICROOP'(8);

  logic [DEPTH-1:0]      ent_valid;
  logic [DEPTH-1:0]      ent_committed;
  logic [ADDR_BITS-1:0]  ent_addr    [DEPTH];
  logic [DATA_WIDTH-1:0] ent_data    [DEPTH];
  logic [MICROOP-1:0]    ent_microop [DEPTH];
  logic [ROB_TICKET-1:0] ent_ticket  [DEPTH];

  logic [PW:0]   head, tail, occupancy, committed_count;
  logic [PW-1:0] head_idx, tail_idx;
  logic          drain, push, push_commit, commit_any;
  logic [DEPTH-1:0] commit_hit, post_committed;

  assign head_idx  = head[PW-1:0];
  assign tail_idx  = tail[PW-1:0];
  assign occupancy = tail - head;
  assign full      = occupancy[PW];
  assign empty     = (occupancy == '0);

  assign cache_wb_valid   = ent_valid[head_idx] & ent_committed[head_idx];
  assign cache_wb_addr    = cache_wb_valid ? ent_addr[head_idx]    : '0;
  assign cache_wb_data    = cache_wb_valid ? ent_data[head_idx]    : '0;
  assign cache_wb_microop = cache_wb_valid ? ent_microop[head_idx] : '0;

  // Handshakes: a store is pushed on st_valid & ~full & ~flush; the head leaves on cache_wb_valid & cache_wb_ready.
  assign drain = cache_wb_valid & cache_wb_ready;
  assign push  = st_valid & ~full & ~flush;

  always_comb begin
    commit_hit      = '0;
    post_committed  = '0;
    committed_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      commit_hit[i] = commit_valid & ent_valid[i] & ~ent_committed[i] &
                      (ent_ticket[i] == commit_ticket);
      post_committed[i] = ent_valid[i] & (ent_committed[i] | commit_hit[i]);
      committed_count   = committed_count + PW1'(post_committed[i]);
    end
  end

  assign commit_any  = |commit_hit;
  assign push_commit = commit_valid & ~commit_any & (st_ticket == commit_ticket);

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid     <= '0;
      ent_committed <= '0;
      head          <= '0;
      tail          <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr[i]    <= '0;
        ent_data[i]    <= '0;
        ent_microop[i] <= '0;
        ent_ticket[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (commit_hit[i]) ent_committed[i] <= 1'b1;
      end
      if (drain) begin
        ent_valid[head_idx]     <= 1'b0;
        ent_committed[head_idx] <= 1'b0;
        head                    <= head + 1'b1;
      end
      // Committed entries are a prefix from head, so the survivors end at head + committed_count.
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (!post_committed[i]) ent_valid[i] <= 1'b0;
        end
        tail <= head + committed_count;
      end else if (push) begin
        ent_valid[tail_idx]     <= 1'b1;
        ent_committed[tail_idx] <= push_commit;
        ent_addr[tail_idx]      <= st_address;
        ent_data[tail_idx]      <= st_data;
        ent_microop[tail_idx]   <= st_microop;
        ent_ticket[tail_idx]    <= st_ticket;
        tail                    <= tail + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(st_valid && full && !flush))
        else $warning("store_buffer: store pushed while full was dropped");
    end
  end

  logic                  fwd_found, fwd_hit;
  logic [ADDR_BITS-1:0]  fwd_addr;
  logic [DATA_WIDTH-1:0] fwd_data, fwd_result;
  logic [MICROOP-1:0]    fwd_microop;

  // Scan oldest to youngest so the last overlap wins; the incoming store is younger than every entry.
  always_comb begin
    fwd_found   = 1'b0;
    fwd_addr    = '0;
    fwd_data    = '0;
    fwd_microop = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((PW1'(i) < occupancy) && ent_valid[head_idx + PW'(i)] &&
          (ent_addr[head_idx + PW'(i)][ADDR_BITS-1:2] == frw_address[ADDR_BITS-1:2])) begin
        fwd_found   = 1'b1;
        fwd_addr    = ent_addr[head_idx + PW'(i)];
        fwd_data    = ent_data[head_idx + PW'(i)];
        fwd_microop = ent_microop[head_idx + PW'(i)];
      end
    end
    if (st_valid && (st_address[ADDR_BITS-1:2] == frw_address[ADDR_BITS-1:2])) begin
      fwd_found   = 1'b1;
      fwd_addr    = st_address;
      fwd_data    = st_data;
      fwd_microop = st_microop;
    end
  end

`ifdef STORE_BUFFER_SUBWORD_FWD_EN
  function automatic logic [2:0] store_size(input logic [MICROOP-1:0] m);
    case (m)
      MICROOP'(6): return 3'd1;
      MICROOP'(7): return 3'd2;
      MICROOP'(8): return 3'd4;
      default:     return 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] load_size(input logic [MICROOP-1:0] m);
    case (m)
      MICROOP'(1), MICROOP'(4): return 3'd1;
      MICROOP'(2), MICROOP'(5): return 3'd2;
      MICROOP'(3):              return 3'd4;
      default:                  return 3'd0;
    endcase
  endfunction

  logic [2:0] ld_size;
  assign ld_size = load_size(frw_microop);
  assign fwd_hit = fwd_found && (fwd_addr == frw_address) && (ld_size != 3'd0) &&
                   (store_size(fwd_microop) >= ld_size);
  assign fwd_result = (ld_size == 3'd1) ? (fwd_data & DATA_WIDTH'(8'hFF))   :
                      (ld_size == 3'd2) ? (fwd_data & DATA_WIDTH'(16'hFFFF)) : fwd_data;
`else
  assign fwd_hit = fwd_found && (fwd_addr == frw_address) &&
                   (fwd_microop == OP_SW) && (frw_microop == OP_LW);
  assign fwd_result = fwd_data;
`endif

  assign frw_valid = fwd_hit;
  assign frw_stall = fwd_found & ~fwd_hit;
  assign frw_data  = fwd_hit ? fwd_result : '0;

endmodule
